contrast_stretch_ctrl: RTL and testbench

- Top-level sequencer for contrast stretching. Runs two gapless passes over source image RAM1.
- Pass 1 streams every pixel into the min/max finder and latches its result.
- Pass 2 re-streams every pixel, together with min and range, into a fixed-latency stretch core and writes the results to destination RAM2 at matching addresses.
- Owns all address generation, read-latency alignment and pass handshakes.

---
 rtl/contrast_stretch_ctrl_if.sv | 44 ++++
 rtl/contrast_stretch_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_contrast_stretch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/contrast_stretch_ctrl_if.sv
// Signal bundle between the contrast-stretch sequencer and its RAMs, min/max finder and stretch core.
// The master side is the sequencer.
interface contrast_stretch_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 17
);
    logic                  start_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  flat_o;
    logic                  ram_rd_en_o;
    logic [ADDR_WIDTH-1:0] ram_rd_addr_o;
    logic [DATA_WIDTH-1:0] ram_rd_data_i;
    logic                  mm_en_o;
    logic [DATA_WIDTH-1:0] mm_data_o;
    logic                  mm_last_o;
    logic                  mm_done_i;
    logic [DATA_WIDTH-1:0] mm_min_i;
    logic [DATA_WIDTH-1:0] mm_max_i;
    logic                  st_valid_o;
    logic [DATA_WIDTH-1:0] st_pixel_o;
    logic [DATA_WIDTH-1:0] st_min_o;
    logic [DATA_WIDTH-1:0] st_range_o;
    logic [DATA_WIDTH-1:0] st_result_i;
    logic                  wr_en_o;
    logic [ADDR_WIDTH-1:0] wr_addr_o;
    logic [DATA_WIDTH-1:0] wr_data_o;

    modport master (
        input  start_i, ram_rd_data_i, mm_done_i, mm_min_i, mm_max_i, st_result_i,
        output busy_o, done_o, flat_o, ram_rd_en_o, ram_rd_addr_o,
               mm_en_o, mm_data_o, mm_last_o,
               st_valid_o, st_pixel_o, st_min_o, st_range_o,
               wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        output start_i, ram_rd_data_i, mm_done_i, mm_min_i, mm_max_i, st_result_i,
        input  busy_o, done_o, flat_o, ram_rd_en_o, ram_rd_addr_o,
               mm_en_o, mm_data_o, mm_last_o,
               st_valid_o, st_pixel_o, st_min_o, st_range_o,
               wr_en_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/contrast_stretch_ctrl.sv
// Two-pass contrast-stretch sequencer: pass 1 feeds RAM1 to the min/max finder,
// pass 2 feeds RAM1 plus min/range to the stretch core and writes results to RAM2.
module contrast_stretch_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 76800,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ST_LATENCY = 3
) (
    input  logic                    clk_i_cs_ctrl,
    input  logic                    rst_i_cs_ctrl,
    contrast_stretch_ctrl_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_SCAN_WAIT, S_STRETCH, S_DRAIN, S_FIN
    } state_t;

    state_t                r_state,   w_state_nxt;
    logic                  r_busy,    w_busy_nxt;
    logic                  r_done,    w_done_nxt;
    logic                  r_flat,    w_flat_nxt;
    logic                  r_rd_en,   w_rd_en_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [DATA_WIDTH-1:0] r_min,     w_min_nxt;
    logic [DATA_WIDTH-1:0] r_range,   w_range_nxt;
    logic                  r_pass_st, w_pass_nxt;

    logic [RD_LATENCY-1:0] r_rv;
    logic [RD_LATENCY-1:0] r_rl;
    logic [ST_LATENCY-1:0] r_sv;
    logic [DATA_WIDTH-1:0] r_pd [ST_LATENCY];

    logic                  w_rd_valid;
    logic                  w_pre_valid;
    logic                  w_rd_last;
    logic                  w_wr_last;
    logic                  w_st_valid;
    logic [DATA_WIDTH-1:0] w_st_pixel;

    assign w_rd_valid = r_rv[RD_LATENCY-1];
    assign w_rd_last  = r_rd_en && (r_rd_addr == LAST_ADDR);
    assign w_wr_last  = r_sv[ST_LATENCY-1] && (r_wr_addr == LAST_ADDR);
    assign w_st_valid = w_rd_valid & r_pass_st;
    assign w_st_pixel = w_st_valid ? bus.ram_rd_data_i : '0;

    // Read-valid one cycle early: the finder start pulse is derived from it.
    generate
        if (RD_LATENCY == 1) begin : g_pre_lat1
            assign w_pre_valid = r_rd_en;
        end else begin : g_pre_latn
            assign w_pre_valid = r_rv[RD_LATENCY-2];
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_flat_nxt    = r_flat;
        w_rd_en_nxt   = r_rd_en;
        w_rd_addr_nxt = r_rd_addr;
        w_wr_addr_nxt = r_sv[ST_LATENCY-1] ? r_wr_addr + ADDR_WIDTH'(1) : r_wr_addr;
        w_min_nxt     = r_min;
        w_range_nxt   = r_range;
        w_pass_nxt    = r_pass_st;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_state_nxt   = S_SCAN;
                    w_busy_nxt    = 1'b1;
                    w_flat_nxt    = 1'b0;
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = '0;
                    w_wr_addr_nxt = '0;
                    w_pass_nxt    = 1'b0;
                end
            end
            S_SCAN, S_STRETCH: begin
                if (w_rd_last) begin
                    w_rd_en_nxt = 1'b0;
                    w_state_nxt = (r_state == S_SCAN) ? S_SCAN_WAIT : S_DRAIN;
                end else begin
                    w_rd_addr_nxt = r_rd_addr + ADDR_WIDTH'(1);
                end
            end
            S_SCAN_WAIT: begin
                if (bus.mm_done_i) begin
                    w_min_nxt     = bus.mm_min_i;
                    w_range_nxt   = bus.mm_max_i - bus.mm_min_i;
                    w_flat_nxt    = (bus.mm_max_i == bus.mm_min_i);
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = '0;
                    w_pass_nxt    = 1'b1;
                    w_state_nxt   = S_STRETCH;
                end
            end
            S_DRAIN: begin
                if (w_wr_last) begin
                    w_state_nxt = S_FIN;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i_cs_ctrl or posedge rst_i_cs_ctrl) begin
        if (rst_i_cs_ctrl) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_flat    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_min     <= '0;
            r_range   <= '0;
            r_pass_st <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_flat    <= w_flat_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_min     <= w_min_nxt;
            r_range   <= w_range_nxt;
            r_pass_st <= w_pass_nxt;
        end
    end

    // Read-latency and stretch-latency alignment pipelines.
    always_ff @(posedge clk_i_cs_ctrl or posedge rst_i_cs_ctrl) begin
        if (rst_i_cs_ctrl) begin
            r_rv <= '0;
            r_rl <= '0;
            r_sv <= '0;
            for (int k = 0; k < ST_LATENCY; k++) begin
                r_pd[k] <= '0;
            end
        end else begin
            r_rv[0] <= r_rd_en;
            r_rl[0] <= w_rd_last;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_rv[k] <= r_rv[k-1];
                r_rl[k] <= r_rl[k-1];
            end
            r_sv[0] <= w_st_valid;
            r_pd[0] <= w_st_pixel;
            for (int k = 1; k < ST_LATENCY; k++) begin
                r_sv[k] <= r_sv[k-1];
                r_pd[k] <= r_pd[k-1];
            end
        end
    end

    assign bus.busy_o        = r_busy;
    assign bus.done_o        = r_done;
    assign bus.flat_o        = r_flat;
    assign bus.ram_rd_en_o   = r_rd_en;
    assign bus.ram_rd_addr_o = r_rd_addr;

    assign bus.mm_en_o       = w_pre_valid & ~w_rd_valid & ~r_pass_st;
    assign bus.mm_data_o     = (w_rd_valid & ~r_pass_st) ? bus.ram_rd_data_i : '0;
    assign bus.mm_last_o     = r_rl[RD_LATENCY-1] & ~r_pass_st;

    assign bus.st_valid_o    = w_st_valid;
    assign bus.st_pixel_o    = w_st_pixel;
    assign bus.st_min_o      = r_min;
    assign bus.st_range_o    = r_range;

    // Flat frames bypass the stretch core (its range would be zero).
    assign bus.wr_en_o       = r_sv[ST_LATENCY-1];
    assign bus.wr_addr_o     = r_wr_addr;
    assign bus.wr_data_o     = r_sv[ST_LATENCY-1] ? (r_flat ? r_pd[ST_LATENCY-1] : bus.st_result_i) : '0;

endmodule

// File: tb/tb_contrast_stretch_ctrl.sv
// Bench for contrast_stretch_ctrl: two instances (read latency 1 and 2) with RAM1, finder and
// stretch-core models; frame table plus write scoreboard.
module tb_contrast_stretch_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned ST    = 3;
    localparam int          NFRM  = 8;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          flat;
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic          mm_en;
        logic [DW-1:0] mm_data;
        logic          mm_last;
        logic          st_valid;
        logic [DW-1:0] st_pixel;
        logic [DW-1:0] st_min;
        logic [DW-1:0] st_range;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
    } obs_t;

    typedef struct {
        int inst;
        int base;
        int step;
        int hold;
        int abort_rst;
        int spur;
        int exp_min;
        int exp_range;
        int exp_flat;
    } frame_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    start;
    logic [1:0]    spur;
    logic [DW-1:0] ram1 [DEPTH];
    obs_t          obs [2];

    int  n_pass = 0;
    int  n_chk  = 0;
    wr_t exp_q [$];

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] min8(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] max8(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Stretch-core behaviour; zero range yields a marker value the DUT must not forward.
    function automatic logic [DW-1:0] stretch_f(input logic [DW-1:0] p, input logic [DW-1:0] mn,
                                                input logic [DW-1:0] rng);
        if (rng == '0) return 8'hAB;
        return DW'((int'(p) - int'(mn)) * 255 / int'(rng));
    endfunction

    function automatic logic [DW-1:0] pix(input int base, input int step, input int i);
        return DW'(base + step * i);
    endfunction

    function automatic int stretch_ref(input int p, input int mn, input int rng, input int flat);
        if (flat != 0) return p;
        return (p - mn) * 255 / rng;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int unsigned RD = g + 1;

        contrast_stretch_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

        contrast_stretch_ctrl #(
            .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
            .RD_LATENCY(RD), .ST_LATENCY(ST)
        ) u_dut (
            .clk_i_cs_ctrl(clk),
            .rst_i_cs_ctrl(rst),
            .bus          (bus)
        );

        logic [DW-1:0] rp [RD];
        logic [DW-1:0] sr [ST];
        logic          f_act;
        logic          f_done;
        logic [DW-1:0] f_lo, f_hi, f_min, f_max;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < int'(RD); k++) rp[k] <= '0;
            end else begin
                rp[0] <= bus.ram_rd_en_o ? ram1[bus.ram_rd_addr_o] : 8'hEE;
                for (int k = 1; k < int'(RD); k++) rp[k] <= rp[k-1];
            end
        end

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                f_act  <= 1'b0;
                f_done <= 1'b0;
                f_lo   <= '0;
                f_hi   <= '0;
                f_min  <= '0;
                f_max  <= '0;
            end else begin
                f_done <= 1'b0;
                if (bus.mm_en_o) begin
                    f_act <= 1'b1;
                    f_lo  <= 8'hFF;
                    f_hi  <= 8'h00;
                end else if (f_act) begin
                    f_lo <= min8(f_lo, bus.mm_data_o);
                    f_hi <= max8(f_hi, bus.mm_data_o);
                    if (bus.mm_last_o) begin
                        f_act  <= 1'b0;
                        f_done <= 1'b1;
                        f_min  <= min8(f_lo, bus.mm_data_o);
                        f_max  <= max8(f_hi, bus.mm_data_o);
                    end
                end
            end
        end

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < int'(ST); k++) sr[k] <= '0;
            end else begin
                sr[0] <= bus.st_valid_o ? stretch_f(bus.st_pixel_o, bus.st_min_o, bus.st_range_o) : '0;
                for (int k = 1; k < int'(ST); k++) sr[k] <= sr[k-1];
            end
        end

        assign bus.start_i       = start[g];
        assign bus.ram_rd_data_i = rp[RD-1];
        assign bus.mm_done_i     = f_done | spur[g];
        assign bus.mm_min_i      = spur[g] ? 8'd0 : f_min;
        assign bus.mm_max_i      = f_max;
        assign bus.st_result_i   = sr[ST-1];

        assign obs[g] = '{busy: bus.busy_o, done: bus.done_o, flat: bus.flat_o,
                          rd_en: bus.ram_rd_en_o, rd_addr: bus.ram_rd_addr_o,
                          mm_en: bus.mm_en_o, mm_data: bus.mm_data_o, mm_last: bus.mm_last_o,
                          st_valid: bus.st_valid_o, st_pixel: bus.st_pixel_o,
                          st_min: bus.st_min_o, st_range: bus.st_range_o,
                          wr_en: bus.wr_en_o, wr_addr: bus.wr_addr_o, wr_data: bus.wr_data_o};
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic do_reset(input int inst);
        rst = 1'b1;
        #1;
        chk("rst_outputs_zero_bits", $countones(obs[inst]), 0);
        chk("rst_st_min", int'(obs[inst].st_min), 0);
        chk("rst_wr_en", int'(obs[inst].wr_en), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", int'(obs[inst].done), 0);
            chk("post_rst_busy", int'(obs[inst].busy), 0);
        end
    endtask

    task automatic run_frame(input frame_t f, input bit cont);
        int   cyc;
        int   mm_start;
        int   mm_cnt;
        int   rd_cnt;
        int   wr_cnt;
        bit   fin;
        bit   spur_done;
        obs_t o;
        wr_t  e;
        cyc = 0; mm_start = -1; mm_cnt = 0; rd_cnt = 0; wr_cnt = 0; fin = 1'b0; spur_done = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram1[i] = pix(f.base, f.step, i);
            exp_q.push_back('{addr: i,
                              data: stretch_ref(int'(ram1[i]), f.exp_min, f.exp_range, f.exp_flat)});
        end
        if (!cont) begin
            @(negedge clk);
            start[f.inst] = 1'b1;
        end
        while (!fin && cyc < 200) begin
            @(negedge clk);
            o = obs[f.inst];
            spur[f.inst] = 1'b0;
            if (cyc == 0) begin
                chk("busy_after_start", int'(o.busy), 1);
                chk("flat_cleared_on_start", int'(o.flat), 0);
                if (f.hold == 0) start[f.inst] = 1'b0;
            end
            if (o.rd_en) rd_cnt++;
            if (o.mm_en) begin
                mm_cnt++;
                mm_start = cyc;
            end
            if (mm_start >= 0 && cyc > mm_start && cyc <= mm_start + int'(DEPTH)) begin
                chk("mm_data", int'(o.mm_data), int'(pix(f.base, f.step, cyc - mm_start - 1)));
                chk("mm_last", int'(o.mm_last), int'(cyc - mm_start == int'(DEPTH)));
            end
            if (f.spur != 0 && !spur_done && o.st_valid && o.rd_addr == AW'(4)) begin
                spur[f.inst] = 1'b1;
                spur_done = 1'b1;
            end
            if (f.abort_rst != 0 && o.st_valid && o.rd_en && o.rd_addr == AW'(7)) begin
                do_reset(f.inst);
                return;
            end
            if (o.wr_en) begin
                wr_cnt++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(o.wr_addr), e.addr);
                    chk("wr_data", int'(o.wr_data), e.data);
                end else begin
                    chk("wr_unexpected", int'(o.wr_en), 0);
                end
            end
            if (o.done) begin
                fin = 1'b1;
                chk("busy_at_done", int'(o.busy), 0);
                chk("st_min", int'(o.st_min), f.exp_min);
                chk("st_range", int'(o.st_range), f.exp_range);
                chk("flat", int'(o.flat), f.exp_flat);
                chk("mm_en_pulses", mm_cnt, 1);
                chk("rd_strobes", rd_cnt, 2 * int'(DEPTH));
                chk("wr_strobes", wr_cnt, int'(DEPTH));
                chk("wr_pending", exp_q.size(), 0);
            end
            cyc++;
        end
        chk("frame_done_seen", int'(fin), 1);
        exp_q.delete();
        if (f.hold != 0) begin
            @(negedge clk);
            chk("fin_ignores_start_busy", int'(obs[f.inst].busy), 0);
            chk("done_single_pulse", int'(obs[f.inst].done), 0);
        end else begin
            repeat (2) begin
                @(negedge clk);
                chk("done_single_pulse", int'(obs[f.inst].done), 0);
                chk("idle_busy", int'(obs[f.inst].busy), 0);
            end
        end
    endtask

    initial begin
        frame_t tbl [NFRM];
        frame_t f2;
        tbl[0] = '{inst: 0, base: 10,  step: 10, hold: 0, abort_rst: 0, spur: 0, exp_min: 10, exp_range: 150, exp_flat: 0};
        tbl[1] = '{inst: 0, base: 77,  step: 0,  hold: 0, abort_rst: 0, spur: 0, exp_min: 77, exp_range: 0,   exp_flat: 1};
        tbl[2] = '{inst: 0, base: 10,  step: 10, hold: 1, abort_rst: 0, spur: 0, exp_min: 10, exp_range: 150, exp_flat: 0};
        tbl[3] = '{inst: 1, base: 10,  step: 10, hold: 0, abort_rst: 0, spur: 0, exp_min: 10, exp_range: 150, exp_flat: 0};
        tbl[4] = '{inst: 1, base: 200, step: -8, hold: 0, abort_rst: 0, spur: 0, exp_min: 80, exp_range: 120, exp_flat: 0};
        tbl[5] = '{inst: 0, base: 5,   step: 13, hold: 0, abort_rst: 1, spur: 0, exp_min: 5,  exp_range: 195, exp_flat: 0};
        tbl[6] = '{inst: 0, base: 5,   step: 13, hold: 0, abort_rst: 0, spur: 1, exp_min: 5,  exp_range: 195, exp_flat: 0};
        tbl[7] = '{inst: 1, base: 77,  step: 0,  hold: 0, abort_rst: 0, spur: 0, exp_min: 77, exp_range: 0,   exp_flat: 1};

        rst   = 1'b0;
        start = '0;
        spur  = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state_inst0", $countones(obs[0]), 0);
        chk("reset_state_inst1", $countones(obs[1]), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NFRM; i++) begin
            run_frame(tbl[i], 1'b0);
            if (tbl[i].hold != 0) begin
                f2 = tbl[i];
                f2.hold = 0;
                run_frame(f2, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
